cory_unpack4: RTL

- Splits one valid/ready stream of Z bits into four independent valid/ready output streams of widths A0..A3.
- Each input word is fanned out into four lane registers. Each lane is handed off on its own handshake.
- The next input word is accepted only once every lane has been taken, or is being taken in the same cycle.
- Sits on the consumer side of a 4-way packer. Together the two form a pack/unpack pair over one wide channel.

---
 rtl/cory_unpack4.sv | 72 +++++++
 1 files changed

// File: rtl/cory_unpack4.sv
// Fans one wide valid/ready word out into four independently handshaked lanes.
// A new word is taken only when every lane is empty or being drained this cycle.
module cory_unpack4 #(
  parameter int N  = 8,
  parameter int A0 = N,
  parameter int A1 = N,
  parameter int A2 = N,
  parameter int A3 = N,
  parameter int Z  = A0 + A1 + A2 + A3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_a_v,
  input  logic [Z-1:0]  i_a_d,
  output logic          o_a_r,
  output logic          o_z0_v,
  output logic [A0-1:0] o_z0_d,
  input  logic          i_z0_r,
  output logic          o_z1_v,
  output logic [A1-1:0] o_z1_d,
  input  logic          i_z1_r,
  output logic          o_z2_v,
  output logic [A2-1:0] o_z2_d,
  input  logic          i_z2_r,
  output logic          o_z3_v,
  output logic [A3-1:0] o_z3_d,
  input  logic          i_z3_r
);

  logic [3:0]    vld_p0;
  logic [A0-1:0] d0_p0;
  logic [A1-1:0] d1_p0;
  logic [A2-1:0] d2_p0;
  logic [A3-1:0] d3_p0;
  logic [3:0]    lane_rdy;
  logic [3:0]    lane_free;
  logic          acc;

  assign lane_rdy  = {i_z3_r, i_z2_r, i_z1_r, i_z0_r};
  assign lane_free = ~vld_p0 | lane_rdy;
  assign o_a_r     = ~reset & (&lane_free);
  assign acc       = i_a_v & o_a_r;

  // Stage p0: lane registers; a lane reloads in the same cycle it drains, so no bubble
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p0 <= 4'b0000;
      d0_p0  <= '0;
      d1_p0  <= '0;
      d2_p0  <= '0;
      d3_p0  <= '0;
    end else if (acc) begin
      vld_p0 <= 4'b1111;
      d0_p0  <= i_a_d[A0-1:0];
      d1_p0  <= i_a_d[A0+A1-1:A0];
      d2_p0  <= i_a_d[A0+A1+A2-1:A0+A1];
      d3_p0  <= i_a_d[Z-1:A0+A1+A2];
    end else begin
      vld_p0 <= vld_p0 & ~lane_rdy;
    end
  end

  assign o_z0_v = vld_p0[0];
  assign o_z1_v = vld_p0[1];
  assign o_z2_v = vld_p0[2];
  assign o_z3_v = vld_p0[3];
  assign o_z0_d = d0_p0;
  assign o_z1_d = d1_p0;
  assign o_z2_d = d2_p0;
  assign o_z3_d = d3_p0;

endmodule
